// File: rtl/turn_signal_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// turn_signal_sequencer_pkg
//
// Shared definitions for the tail-light sequencer:
//   - state_t      : controller states (IDLE, LEFT, RIGHT, HAZARD, ERROR)
//   - lamp pattern constants for the left and right banks
//   - HEX2 seven-segment codes (active-low) for "E" and blank
//   - helper functions that map a 2-bit phase onto a bank pattern
// -----------------------------------------------------------------------------
package turn_signal_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEFT   = 3'd1,
    ST_RIGHT  = 3'd2,
    ST_HAZARD = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam logic [2:0] LAMPS_OFF = 3'b000;
  localparam logic [2:0] LAMPS_ON  = 3'b111;

  // Left bank: bit0 is the innermost lamp, so the sweep grows from bit0 up.
  localparam logic [2:0] LEFT_PAT_P0 = 3'b001;
  localparam logic [2:0] LEFT_PAT_P1 = 3'b011;
  localparam logic [2:0] LEFT_PAT_P2 = 3'b111;
  localparam logic [2:0] LEFT_PAT_P3 = 3'b000;

  // Right bank: bit2 is the innermost lamp, so the sweep grows from bit2 down.
  localparam logic [2:0] RIGHT_PAT_P0 = 3'b100;
  localparam logic [2:0] RIGHT_PAT_P1 = 3'b110;
  localparam logic [2:0] RIGHT_PAT_P2 = 3'b111;
  localparam logic [2:0] RIGHT_PAT_P3 = 3'b000;

  // Active-low seven-segment codes.
  localparam logic [6:0] HEX_ERROR = 7'b0000110;
  localparam logic [6:0] HEX_BLANK = 7'b1111111;

  function automatic logic [2:0] left_pattern(input logic [1:0] phase);
    logic [2:0] pat;
    case (phase)
      2'd0:    pat = LEFT_PAT_P0;
      2'd1:    pat = LEFT_PAT_P1;
      2'd2:    pat = LEFT_PAT_P2;
      default: pat = LEFT_PAT_P3;
    endcase
    return pat;
  endfunction

  function automatic logic [2:0] right_pattern(input logic [1:0] phase);
    logic [2:0] pat;
    case (phase)
      2'd0:    pat = RIGHT_PAT_P0;
      2'd1:    pat = RIGHT_PAT_P1;
      2'd2:    pat = RIGHT_PAT_P2;
      default: pat = RIGHT_PAT_P3;
    endcase
    return pat;
  endfunction

  // States in which the phase counter is allowed to advance.
  function automatic logic is_sequencing(input state_t st);
    return (st == ST_LEFT) || (st == ST_RIGHT) || (st == ST_HAZARD);
  endfunction

endpackage

// File: rtl/turn_signal_sequencer_blink_prescaler.sv
// -----------------------------------------------------------------------------
// turn_signal_sequencer_blink_prescaler
//
// Free-running divider that produces a single-cycle tick once every TICK_DIV
// clocks. The count runs 0..TICK_DIV-1 and wraps; tick is high while the count
// sits at TICK_DIV-1. A synchronous clear restarts the count at 0 so that the
// first blink step after a state change lasts a full TICK_DIV clocks.
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset (count -> 0)
//   clr  - synchronous clear (count -> 0 on the next edge)
//   tick - high during the last clock of each TICK_DIV period
// -----------------------------------------------------------------------------
module turn_signal_sequencer_blink_prescaler #(
  parameter int TICK_DIV = 25000000,
  parameter int CNT_W    = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_count;
  logic             w_at_last;

  assign w_at_last = (r_count == LP_LAST);
  assign tick      = w_at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr || w_at_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + LP_ONE;
    end
  end

endmodule

// File: rtl/turn_signal_sequencer.sv
// -----------------------------------------------------------------------------
// turn_signal_sequencer
//
// Sequences the 3-lamp left/right tail-light banks and arbitrates between
// turn, hazard and brake requests. A blink prescaler paces the lamp phases
// at TICK_DIV clocks per step. Conflicting turn requests show "E" on HEX2.
//
// Ports:
//   clk        - system clock, all state changes on the rising edge
//   rst        - asynchronous active-high reset
//   left       - left-turn request (level)
//   right      - right-turn request (level)
//   hazard     - hazard request (level), highest priority
//   brake      - brake pedal (level), overlays non-sequencing banks
//   leftLight  - left bank, bit0 innermost .. bit2 outermost (registered)
//   rightLight - right bank, bit2 innermost .. bit0 outermost (registered)
//   HEX2       - active-low seven-segment, "E" in ERROR else blank (registered)
//   busy       - high whenever the state is not IDLE (registered)
//
// All outputs are computed from the next state/phase and registered, so the
// response to inputs sampled at edge n is visible right after edge n.
// -----------------------------------------------------------------------------
module turn_signal_sequencer #(
  parameter int TICK_DIV = 25000000,
  parameter int CNT_W    = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       left,
  input  logic       right,
  input  logic       hazard,
  input  logic       brake,
  output logic [2:0] leftLight,
  output logic [2:0] rightLight,
  output logic [6:0] HEX2,
  output logic       busy
);

  import turn_signal_sequencer_pkg::*;

  state_t     r_state;
  state_t     w_target;
  state_t     w_state_next;
  logic [1:0] r_phase;
  logic [1:0] w_phase_next;
  logic       w_state_change;
  logic       w_tick;

  logic [2:0] r_left_light;
  logic [2:0] r_right_light;
  logic [6:0] r_hex2;
  logic       r_busy;
  logic [2:0] w_left_next;
  logic [2:0] w_right_next;
  logic [6:0] w_hex_next;
  logic       w_busy_next;

  // ---------------------------------------------------------------------------
  // Blink-rate prescaler; restarted on every state change.
  // ---------------------------------------------------------------------------
  turn_signal_sequencer_blink_prescaler #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_blink_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_state_change),
    .tick (w_tick)
  );

  // ---------------------------------------------------------------------------
  // Request arbitration, evaluated every cycle in priority order.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_target = ST_IDLE;
    if (hazard) begin
      w_target = ST_HAZARD;
    end else if (left && right) begin
      w_target = ST_ERROR;
    end else if (left) begin
      w_target = ST_LEFT;
    end else if (right) begin
      w_target = ST_RIGHT;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and phase.
  // A direct swap between the two turn directions is not allowed: the
  // controller parks in IDLE for one cycle so the old bank visibly goes dark
  // before the other bank starts its sweep.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = w_target;
    if ((r_state == ST_LEFT) && (w_target == ST_RIGHT)) begin
      w_state_next = ST_IDLE;
    end else if ((r_state == ST_RIGHT) && (w_target == ST_LEFT)) begin
      w_state_next = ST_IDLE;
    end

    w_state_change = (w_state_next != r_state);

    // A state change outranks a coincident tick: the new state starts at
    // phase 0 with a freshly cleared prescaler.
    w_phase_next = r_phase;
    if (w_state_change) begin
      w_phase_next = 2'd0;
    end else if (w_tick && is_sequencing(r_state)) begin
      w_phase_next = r_phase + 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode from the next state/phase, including the brake overlay.
  // The overlay lights any bank that is not currently sweeping a turn; the
  // hazard flasher owns both banks and ignores the brake entirely.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_left_next  = LAMPS_OFF;
    w_right_next = LAMPS_OFF;
    w_hex_next   = HEX_BLANK;
    w_busy_next  = (w_state_next != ST_IDLE);

    case (w_state_next)
      ST_LEFT: begin
        w_left_next = left_pattern(w_phase_next);
        if (brake) begin
          w_right_next = LAMPS_ON;
        end
      end
      ST_RIGHT: begin
        w_right_next = right_pattern(w_phase_next);
        if (brake) begin
          w_left_next = LAMPS_ON;
        end
      end
      ST_HAZARD: begin
        // Even phases on, odd phases off: a TICK_DIV-clock on/off flash.
        if (!w_phase_next[0]) begin
          w_left_next  = LAMPS_ON;
          w_right_next = LAMPS_ON;
        end
      end
      ST_ERROR: begin
        w_hex_next = HEX_ERROR;
        if (brake) begin
          w_left_next  = LAMPS_ON;
          w_right_next = LAMPS_ON;
        end
      end
      default: begin
        if (brake) begin
          w_left_next  = LAMPS_ON;
          w_right_next = LAMPS_ON;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, phase and output registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_phase       <= 2'd0;
      r_left_light  <= LAMPS_OFF;
      r_right_light <= LAMPS_OFF;
      r_hex2        <= HEX_BLANK;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_phase       <= w_phase_next;
      r_left_light  <= w_left_next;
      r_right_light <= w_right_next;
      r_hex2        <= w_hex_next;
      r_busy        <= w_busy_next;
    end
  end

  assign leftLight  = r_left_light;
  assign rightLight = r_right_light;
  assign HEX2       = r_hex2;
  assign busy       = r_busy;

endmodule

// File: tb/tb_turn_signal_sequencer.sv
// -----------------------------------------------------------------------------
// tb_turn_signal_sequencer
//
// Directed scenarios followed by randomized request sequences. The reference
// model tracks only the current mode and how many edges have elapsed since
// that mode was entered; the lamp phase is derived arithmetically from that
// elapsed count and looked up in pattern tables.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_turn_signal_sequencer;

  localparam int TDIV = 4;

  // Model modes (bench-local numbering).
  localparam int M_IDLE   = 0;
  localparam int M_LEFT   = 1;
  localparam int M_RIGHT  = 2;
  localparam int M_HAZARD = 3;
  localparam int M_ERROR  = 4;

  logic       clk;
  logic       rst;
  logic       left;
  logic       right;
  logic       hazard;
  logic       brake;
  logic [2:0] leftLight;
  logic [2:0] rightLight;
  logic [6:0] HEX2;
  logic       busy;

  int vectors;
  int miscompares;

  // Reference model state.
  int         m_mode;
  int         m_k;
  logic [2:0] m_left;
  logic [2:0] m_right;
  logic [6:0] m_hex;
  logic       m_busy;

  logic [2:0] left_pat  [4];
  logic [2:0] right_pat [4];

  turn_signal_sequencer #(
    .TICK_DIV (TDIV),
    .CNT_W    (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .left       (left),
    .right      (right),
    .hazard     (hazard),
    .brake      (brake),
    .leftLight  (leftLight),
    .rightLight (rightLight),
    .HEX2       (HEX2),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_k     = 0;
    m_left  = 3'b000;
    m_right = 3'b000;
    m_hex   = 7'b1111111;
    m_busy  = 1'b0;
  endtask

  task automatic model_edge(input logic l, input logic r, input logic h,
                            input logic b);
    int tgt;
    int nm;
    int ph;
    if (h)           tgt = M_HAZARD;
    else if (l && r) tgt = M_ERROR;
    else if (l)      tgt = M_LEFT;
    else if (r)      tgt = M_RIGHT;
    else             tgt = M_IDLE;
    nm = tgt;
    if ((m_mode == M_LEFT && tgt == M_RIGHT) ||
        (m_mode == M_RIGHT && tgt == M_LEFT)) nm = M_IDLE;
    if (nm != m_mode) begin
      m_mode = nm;
      m_k    = 0;
    end else begin
      m_k = m_k + 1;
    end
    ph      = (m_k / TDIV) % 4;
    m_left  = 3'b000;
    m_right = 3'b000;
    m_hex   = 7'b1111111;
    case (m_mode)
      M_LEFT: begin
        m_left = left_pat[ph];
        if (b) m_right = 3'b111;
      end
      M_RIGHT: begin
        m_right = right_pat[ph];
        if (b) m_left = 3'b111;
      end
      M_HAZARD: begin
        m_left  = (ph % 2 == 0) ? 3'b111 : 3'b000;
        m_right = m_left;
      end
      M_ERROR: begin
        m_hex = 7'b0000110;
        if (b) begin m_left = 3'b111; m_right = 3'b111; end
      end
      default: begin
        if (b) begin m_left = 3'b111; m_right = 3'b111; end
      end
    endcase
    m_busy = (m_mode != M_IDLE);
  endtask

  task automatic check(input string tag);
    vectors = vectors + 1;
    assert (leftLight === m_left) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s leftLight got %b exp %b", tag, leftLight, m_left);
    end
    vectors = vectors + 1;
    assert (rightLight === m_right) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s rightLight got %b exp %b", tag, rightLight, m_right);
    end
    vectors = vectors + 1;
    assert (HEX2 === m_hex) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s HEX2 got %b exp %b", tag, HEX2, m_hex);
    end
    vectors = vectors + 1;
    assert (busy === m_busy) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s busy got %b exp %b", tag, busy, m_busy);
    end
    $display("[%0t] %s in l=%b r=%b h=%b b=%b out L=%b R=%b HEX=%b busy=%b",
             $time, tag, left, right, hazard, brake, leftLight, rightLight,
             HEX2, busy);
  endtask

  // One clock: drive inputs, let the edge happen, update model, check.
  task automatic step(input logic l, input logic r, input logic h,
                      input logic b, input string tag);
    left   = l;
    right  = r;
    hazard = h;
    brake  = b;
    @(posedge clk);
    model_edge(l, r, h, b);
    #1;
    check(tag);
  endtask

  task automatic hold(input logic l, input logic r, input logic h,
                      input logic b, input int n, input string tag);
    for (int i = 0; i < n; i++) step(l, r, h, b, tag);
  endtask

  // Asynchronous reset between edges; outputs must clear with no clock.
  task automatic async_reset_pulse(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    left_pat  = '{3'b001, 3'b011, 3'b111, 3'b000};
    right_pat = '{3'b100, 3'b110, 3'b111, 3'b000};

    rst    = 1'b1;
    left   = 1'b0;
    right  = 1'b0;
    hazard = 1'b0;
    brake  = 1'b0;
    model_reset();
    #2;
    check("reset");
    @(negedge clk);
    rst = 1'b0;

    // Left sweep held for 20 clocks (includes wrap back to 001).
    hold(1'b1, 1'b0, 1'b0, 1'b0, 20, "left_seq");

    // Idle, then right for 6 clocks, then release.
    hold(1'b0, 1'b0, 1'b0, 1'b0, 2, "idle");
    hold(1'b0, 1'b1, 1'b0, 1'b0, 6, "right_seq");
    step(1'b0, 1'b0, 1'b0, 1'b0, "right_drop");

    // Conflict then resolve to LEFT.
    hold(1'b1, 1'b1, 1'b0, 1'b0, 3, "conflict");
    hold(1'b1, 1'b0, 1'b0, 1'b0, 3, "conflict_clear");

    // Direct LEFT->RIGHT request must pass through IDLE.
    hold(1'b0, 1'b1, 1'b0, 1'b0, 3, "left_to_right");
    hold(1'b1, 1'b0, 1'b0, 1'b0, 2, "right_to_left");

    // Brake overlay while turning left, then brake alone.
    hold(1'b0, 1'b0, 1'b0, 1'b0, 2, "idle");
    hold(1'b1, 1'b0, 1'b0, 1'b1, 10, "left_brake");
    hold(1'b0, 1'b0, 1'b0, 1'b1, 3, "brake_only");

    // Hazard overrides left and brake; release returns to LEFT at phase 0.
    hold(1'b1, 1'b0, 1'b1, 1'b1, 12, "hazard");
    hold(1'b1, 1'b0, 1'b0, 1'b1, 3, "hazard_release");

    // Async reset mid-phase 2 of LEFT, then restart with left held.
    hold(1'b0, 1'b0, 1'b0, 1'b0, 1, "idle");
    hold(1'b1, 1'b0, 1'b0, 1'b0, 9, "left_to_p2");
    async_reset_pulse("async_reset");
    hold(1'b1, 1'b0, 1'b0, 1'b0, 2, "after_reset");

    // Randomized request sequences.
    for (int s = 0; s < 300; s++) begin
      logic l;
      logic r;
      logic h;
      logic b;
      int   n;
      n = int'($urandom_range(1, 12));
      h = ($urandom_range(0, 7) == 0);
      l = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) async_reset_pulse("rand_reset");
      hold(l, r, h, b, n, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
